// File: rtl/ffra_collect_pkg.sv
// Shared constants and entry layout for the ffra result collector.
package ffra_collect_pkg;

    localparam int FFRA_DATA_W    = 16;
    localparam int FFRA_ACC_W_DEF = 24;

    typedef struct packed {
        logic [FFRA_DATA_W-1:0]    data;
        logic [FFRA_ACC_W_DEF-1:0] acc;
    } ffra_entry_t;

endpackage

// File: rtl/ffra_collect_fifo.sv
// Synchronous FIFO for collector entries; a pop frees a slot for a same-cycle push.
module ffra_collect_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_req,
    input  logic                   pop_req,
    input  logic [W-1:0]           din,
    output logic                   push_ok,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           dout
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          pop_ok;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_req && !empty;
        push_ok  = push_req && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    // Storage is reset too so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ffra_result_collector.sv
// Captures latency-aligned ffra results with a running accumulator into a FIFO.
// Define FFRA_COLLECT_SAT_EN to saturate the accumulator instead of wrapping.
module ffra_result_collector
    import ffra_collect_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4,
    parameter int ACC_W   = FFRA_ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [15:0]            ffra_o,
    input  logic                   acc_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic [ACC_W-1:0]       out_acc,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam int ENTRY_W = FFRA_DATA_W + ACC_W;
`ifdef FFRA_COLLECT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic logic [ACC_W-1:0] fit_acc(input logic [ACC_W:0] sum);
        return (SAT_EN && sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    logic               cap;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_base, acc_next;
    logic [ACC_W:0]     acc_sum;
    logic               overflow_q, overflow_d;
    logic               pop, drop, push_ok, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;

    generate
        if (LATENCY == 0) begin : g_no_align
            assign cap = in_valid;
        end else begin : g_align
            logic [LATENCY-1:0] align_q, align_d;
            always_comb begin
                align_d[0] = in_valid;
                for (int i = 1; i < LATENCY; i++) align_d[i] = align_q[i-1];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) align_q <= '0;
                else        align_q <= align_d;
            end
            assign cap = align_q[LATENCY-1];
        end
    endgenerate

    always_comb begin
        acc_base = acc_clear ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(ffra_o);
        acc_next = fit_acc(acc_sum);
        pop      = !fifo_empty && out_ready;
        drop     = cap && fifo_full && !pop;
        acc_d    = acc_q;
        if (push_ok)        acc_d = acc_next;
        else if (acc_clear) acc_d = '0;
        // A drop in the same cycle as a clear request leaves the flag set.
        overflow_d = overflow_q;
        if (overflow_clr) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    ffra_collect_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_req (cap),
        .pop_req  (out_ready),
        .din      ({ffra_o, acc_next}),
        .push_ok  (push_ok),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .dout     (fifo_dout)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout[ENTRY_W-1:ACC_W];
    assign out_acc   = fifo_dout[ACC_W-1:0];
    assign overflow  = overflow_q;

endmodule
